register_status_file: RTL and testbench
=======================================

// Module: register_status_file
// PURPOSE
// - Architectural register file with Tomasulo-style rename tags. Sits directly upstream of the add/mul/mem reservation stations.
// - Each cycle it reads one instruction's two sources and presents each to the reservation stations as either data or a producer tag.
// - It renames the destination register to the tag of the accepting station slot.
// - It snoops the 3-lane CDB and retires values back into registers whose pending tag matches.
// PARAMETERS
// - NUM_REGS  16  architectural registers; address width = $clog2(NUM_REGS); r0 hardwired to zero
// - XLEN      32  data width
// - CDB_LANES 3   CDB lanes; lane 0 occupies the MSBs of the serialized buses
// PORTS
// - clk                  in   1    clock, rising edge
// - reset                in   1    asynchronous, active-high
// - en                   in   1    global enable; when low, no state changes
// - instr_valid          in   1    decoded instruction present
// - instr_unit           in   2    0=add, 1=mul, 2=mem, 3=illegal (never accepted)
// - instr_rd             in   4    destination register
// - instr_rs1, instr_rs2 in   4    source registers
// - acceptor_tag_add     in   8    {valid,mem,add,mul,0,id[2:0]} offered by the add station; same format for mul and mem
// - acceptor_tag_mul     in   8
// - acceptor_tag_mem     in   8
// - CDB_data_serialized  in   96   {lane0,lane1,lane2} data
// - CDB_tag_serialized   in   24   {lane0,lane1,lane2} tags; bit7 = tag valid
// - instr_ready          out  1    selected unit's acceptor_tag[7] && instr_unit!=3
// - src_out_1, src_out_2 out  32   register data, or {24'h0,tag} when the type bit is set
// - src_out1_type, src_out2_type out 1  0=data, 1=tag
// - src_valid_add, src_valid_mul, src_valid_mem out 1  one-hot dispatch strobe = instr_valid && instr_ready && en, routed by instr_unit
// - pending_count        out  5    number of registers currently holding a tag
// BEHAVIOUR
// - Reset (async): all regs = 0, all tags cleared; pending_count=0. Strobes deassert combinationally (depend on en/instr_valid).
// - Reads and strobes are combinational, zero latency, valid in the same cycle as acceptor_tag; rename and CDB writes commit at posedge.
// - Per register: {busy, tag[7:0], value[31:0]}. Read: busy ? (type=1, out=tag) : (type=0, out=value).
// - r0: always reads data 0, type 0; never renamed; CDB writes to it are ignored.
// - Dispatch (strobe high): if rd!=0: busy[rd]<=1, tag[rd]<=selected acceptor_tag; value unchanged.
// - Sources are read before the rename, so rs==rd sees the old mapping.
// - CDB retire: for each register with busy && tag==lane tag (all 8 bits, lane bit7=1): value<=lane data, busy<=0.
// - Multiple lanes carrying the same tag is illegal; lane 0 wins.
// - Same-cycle rename and CDB retire on the same rd: rename wins (busy stays 1, new tag). The retired value is discarded for that register.
// - Stale broadcast (tag no longer current for any register): no effect.
// - instr_valid with instr_ready=0: no strobe, no state change; the decoder holds the instruction (stall).
// - en=0: no state updates; strobes low; reads still combinational.
// - pending_count is registered: popcount of busy after the cycle's updates. Range 0..NUM_REGS-1.
// CONFIGURATION
// - CDB_BYPASS_EN defined: if a source register is busy and its tag appears on a CDB lane this cycle, output that lane's data with type=0.
//   The register update still happens at the edge.
// - CDB_BYPASS_EN undefined: the source reads as a tag that cycle. The reservation station catches it on a later broadcast, or it was just broadcast.
//   The team therefore builds with CDB_BYPASS_EN to avoid a lost wakeup.
// TESTING
// - Reset mid-run with r3 busy -> r3 reads 0/type 0 immediately after reset asserts, pending_count=0.
// - add rd=r3 rs1=r1 rs2=r2, r1=5, r2=7, acceptor_tag_add=8'hC1 -> src_valid_add=1, outputs 5/7 type 0; next cycle r3 reads 8'hC1 type 1, pending_count=1.
// - CDB lane1 tag 8'hC1 data 32'd12 -> next cycle r3 reads 12 type 0, pending_count=0. Lane tag 8'hC2 -> no change.
// - Same cycle: rename r3 to 8'hA0 and CDB retires 8'hC1 -> r3 reads 8'hA0 type 1.
// - rd=0, or acceptor_tag_mul[7]=0 with unit=mul -> no rename. In the not-ready case, instr_ready=0 and all strobes are low.
// - CDB_BYPASS_EN: r4 busy tag 8'h91, lane 0 broadcasts 8'h91/32'hDEAD while rs1=r4 dispatches -> src_out_1=32'hDEAD, type 0.

Source files
------------

// File: rtl/register_status_file_if.sv
// Dispatch-side bundle for register_status_file: decoded instruction, station acceptor tags,
// CDB snoop lanes, and the source/strobe outputs toward the reservation stations.
interface register_status_file_if #(
    parameter int NUM_REGS  = 16,
    parameter int XLEN      = 32,
    parameter int CDB_LANES = 3
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS) + 1;

    logic                      en;
    logic                      instr_valid;
    logic [1:0]                instr_unit;
    logic [AW-1:0]             instr_rd;
    logic [AW-1:0]             instr_rs1;
    logic [AW-1:0]             instr_rs2;
    logic [7:0]                acceptor_tag_add;
    logic [7:0]                acceptor_tag_mul;
    logic [7:0]                acceptor_tag_mem;
    logic [CDB_LANES*XLEN-1:0] CDB_data_serialized;
    logic [CDB_LANES*8-1:0]    CDB_tag_serialized;

    logic                      instr_ready;
    logic [XLEN-1:0]           src_out_1;
    logic [XLEN-1:0]           src_out_2;
    logic                      src_out1_type;
    logic                      src_out2_type;
    logic                      src_valid_add;
    logic                      src_valid_mul;
    logic                      src_valid_mem;
    logic [CW-1:0]             pending_count;

    modport master (
        output en, instr_valid, instr_unit, instr_rd, instr_rs1, instr_rs2,
               acceptor_tag_add, acceptor_tag_mul, acceptor_tag_mem,
               CDB_data_serialized, CDB_tag_serialized,
        input  instr_ready, src_out_1, src_out_2, src_out1_type, src_out2_type,
               src_valid_add, src_valid_mul, src_valid_mem, pending_count
    );

    modport slave (
        input  en, instr_valid, instr_unit, instr_rd, instr_rs1, instr_rs2,
               acceptor_tag_add, acceptor_tag_mul, acceptor_tag_mem,
               CDB_data_serialized, CDB_tag_serialized,
        output instr_ready, src_out_1, src_out_2, src_out1_type, src_out2_type,
               src_valid_add, src_valid_mul, src_valid_mem, pending_count
    );
endinterface

// File: rtl/register_status_file.sv
// Architectural register file with rename tags, feeding the add/mul/mem reservation stations.
// Optional CDB_BYPASS_EN: forward a same-cycle CDB broadcast to a busy source instead of its tag.
module register_status_file #(
    parameter int NUM_REGS  = 16,
    parameter int XLEN      = 32,
    parameter int CDB_LANES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    register_status_file_if.slave   bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS) + 1;

    logic [XLEN-1:0]     r_value [NUM_REGS];
    logic [7:0]          r_tag   [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [CW-1:0]       r_pending_count;

    logic [XLEN-1:0]     w_value_next [NUM_REGS];
    logic [7:0]          w_tag_next   [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy_next;
    logic [CW-1:0]       w_pending_next;

    logic [7:0]          w_lane_tag  [CDB_LANES];
    logic [XLEN-1:0]     w_lane_data [CDB_LANES];
    logic [NUM_REGS-1:0] w_hit;
    logic [XLEN-1:0]     w_hit_data [NUM_REGS];

    logic [7:0]          w_sel_tag;
    logic                w_ready;
    logic                w_dispatch;

    // Lane 0 sits in the most significant slice of both serialized buses.
    genvar gi;
    generate
        for (gi = 0; gi < CDB_LANES; gi++) begin : g_lane
            assign w_lane_tag[gi]  = bus.CDB_tag_serialized[(CDB_LANES-1-gi)*8 +: 8];
            assign w_lane_data[gi] = bus.CDB_data_serialized[(CDB_LANES-1-gi)*XLEN +: XLEN];
        end
    endgenerate

    always_comb begin
        w_sel_tag = 8'h00;
        case (bus.instr_unit)
            2'd0:    w_sel_tag = bus.acceptor_tag_add;
            2'd1:    w_sel_tag = bus.acceptor_tag_mul;
            2'd2:    w_sel_tag = bus.acceptor_tag_mem;
            default: w_sel_tag = 8'h00;
        endcase
    end

    assign w_ready           = w_sel_tag[7] && (bus.instr_unit != 2'd3);
    assign w_dispatch        = bus.en && bus.instr_valid && w_ready;
    assign bus.instr_ready   = w_ready;
    assign bus.src_valid_add = w_dispatch && (bus.instr_unit == 2'd0);
    assign bus.src_valid_mul = w_dispatch && (bus.instr_unit == 2'd1);
    assign bus.src_valid_mem = w_dispatch && (bus.instr_unit == 2'd2);
    assign bus.pending_count = r_pending_count;

    // Scan lanes from the highest index down so lane 0 has the final say on duplicate tags.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_hit[i]      = 1'b0;
            w_hit_data[i] = '0;
            for (int l = CDB_LANES - 1; l >= 0; l--) begin
                if (w_lane_tag[l][7] && (w_lane_tag[l] == r_tag[i])) begin
                    w_hit[i]      = 1'b1;
                    w_hit_data[i] = w_lane_data[l];
                end
            end
        end
    end

    // Retire first, then rename, so a same-cycle rename of the retiring register keeps it busy.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_value_next[i] = r_value[i];
            w_tag_next[i]   = r_tag[i];
            w_busy_next[i]  = r_busy[i];
        end
        if (bus.en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (r_busy[i] && w_hit[i]) begin
                    w_value_next[i] = w_hit_data[i];
                    w_busy_next[i]  = 1'b0;
                end
            end
            if (w_dispatch && (bus.instr_rd != '0)) begin
                w_busy_next[bus.instr_rd] = 1'b1;
                w_tag_next[bus.instr_rd]  = w_sel_tag;
            end
        end
    end

    always_comb begin
        w_pending_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_pending_next = w_pending_next + CW'(w_busy_next[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy          <= '0;
            r_pending_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_value[i] <= w_value_next[i];
                r_tag[i]   <= w_tag_next[i];
            end
            r_busy          <= w_busy_next;
            r_pending_count <= w_pending_next;
        end
    end

    // Source reads see the pre-edge mapping, so rs == rd returns the old value or tag.
    logic [AW-1:0] w_rs [2];
    assign w_rs[0] = bus.instr_rs1;
    assign w_rs[1] = bus.instr_rs2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [XLEN-1:0] w_src;
            logic            w_src_type;
            always_comb begin
                w_src      = '0;
                w_src_type = 1'b0;
                if (w_rs[gi] != '0) begin
                    if (r_busy[w_rs[gi]]) begin
                        w_src      = XLEN'(r_tag[w_rs[gi]]);
                        w_src_type = 1'b1;
`ifdef CDB_BYPASS_EN
                        if (w_hit[w_rs[gi]]) begin
                            w_src      = w_hit_data[w_rs[gi]];
                            w_src_type = 1'b0;
                        end
`endif
                    end else begin
                        w_src = r_value[w_rs[gi]];
                    end
                end
            end
        end
    endgenerate

    assign bus.src_out_1     = g_src[0].w_src;
    assign bus.src_out1_type = g_src[0].w_src_type;
    assign bus.src_out_2     = g_src[1].w_src;
    assign bus.src_out2_type = g_src[1].w_src_type;
endmodule

// File: tb/tb_register_status_file.sv
// Directed bench for register_status_file: rename, CDB retire, stalls, enable, r0, bypass, async reset.
module tb_register_status_file;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    register_status_file_if bus ();
    register_status_file dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic quiet();
        bus.en = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_unit = 2'd0;
        bus.instr_rd = 4'd0;
        bus.instr_rs1 = 4'd0;
        bus.instr_rs2 = 4'd0;
        bus.acceptor_tag_add = 8'h00;
        bus.acceptor_tag_mul = 8'h00;
        bus.acceptor_tag_mem = 8'h00;
        bus.CDB_data_serialized = '0;
        bus.CDB_tag_serialized = '0;
    endtask

    task automatic lane(input int l, input logic [7:0] t, input logic [31:0] d);
        bus.CDB_tag_serialized[(2-l)*8 +: 8]   = t;
        bus.CDB_data_serialized[(2-l)*32 +: 32] = d;
    endtask

    task automatic issue(input logic [1:0] unit, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        bus.instr_valid = 1'b1;
        bus.instr_unit = unit;
        bus.instr_rd = rd;
        bus.instr_rs1 = rs1;
        bus.instr_rs2 = rs2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        #12;
        bus.instr_rs1 = 4'd3;
        #1;
        chk("reset_src1", bus.src_out_1, 32'd0);
        chk("reset_src1_type", bus.src_out1_type, 1'b0);
        chk("reset_pending", bus.pending_count, 5'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // r1 <- tag C5
        quiet(); issue(2'd0, 4'd1, 4'd0, 4'd0); bus.acceptor_tag_add = 8'hC5; #1;
        chk("r1_rename_strobe", bus.src_valid_add, 1'b1);
        tick();

        // r2 <- tag C6 while C5 retires value 5 into r1
        quiet(); issue(2'd0, 4'd2, 4'd1, 4'd0); bus.acceptor_tag_add = 8'hC6; lane(0, 8'hC5, 32'd5); #1;
`ifdef CDB_BYPASS_EN
        chk("r1_bypass_data", bus.src_out_1, 32'd5);
        chk("r1_bypass_type", bus.src_out1_type, 1'b0);
`else
        chk("r1_tag_read", bus.src_out_1, 32'h0000_00C5);
        chk("r1_tag_type", bus.src_out1_type, 1'b1);
`endif
        tick();

        quiet(); bus.instr_rs1 = 4'd1; bus.instr_rs2 = 4'd2; #1;
        chk("r1_value", bus.src_out_1, 32'd5);
        chk("r2_tag", bus.src_out_2, 32'h0000_00C6);
        chk("r2_type", bus.src_out2_type, 1'b1);
        chk("pending_after_r2", bus.pending_count, 5'd1);
        lane(2, 8'hC6, 32'd7);
        tick();

        // add r3 = r1 + r2, accepted with tag C1
        quiet(); issue(2'd0, 4'd3, 4'd1, 4'd2); bus.acceptor_tag_add = 8'hC1; #1;
        chk("add_ready", bus.instr_ready, 1'b1);
        chk("add_strobe_add", bus.src_valid_add, 1'b1);
        chk("add_strobe_mul", bus.src_valid_mul, 1'b0);
        chk("add_strobe_mem", bus.src_valid_mem, 1'b0);
        chk("add_src1", bus.src_out_1, 32'd5);
        chk("add_src1_type", bus.src_out1_type, 1'b0);
        chk("add_src2", bus.src_out_2, 32'd7);
        chk("add_src2_type", bus.src_out2_type, 1'b0);
        chk("pending_zero", bus.pending_count, 5'd0);
        tick();

        quiet(); bus.instr_rs1 = 4'd3; #1;
        chk("r3_tag", bus.src_out_1, 32'h0000_00C1);
        chk("r3_tag_type", bus.src_out1_type, 1'b1);
        chk("pending_r3", bus.pending_count, 5'd1);
        lane(1, 8'hC2, 32'd99);
        tick();

        quiet(); bus.instr_rs1 = 4'd3; #1;
        chk("stale_tag", bus.src_out_1, 32'h0000_00C1);
        chk("stale_type", bus.src_out1_type, 1'b1);
        chk("stale_pending", bus.pending_count, 5'd1);
        lane(1, 8'hC1, 32'd12);
        tick();

        quiet(); bus.instr_rs1 = 4'd3; #1;
        chk("retire_value", bus.src_out_1, 32'd12);
        chk("retire_type", bus.src_out1_type, 1'b0);
        chk("retire_pending", bus.pending_count, 5'd0);

        // mem op renames r3 to C1 again; rs1==rd sees the old value
        issue(2'd2, 4'd3, 4'd3, 4'd0); bus.acceptor_tag_mem = 8'hC1; #1;
        chk("rsrd_old_value", bus.src_out_1, 32'd12);
        chk("mem_strobe", bus.src_valid_mem, 1'b1);
        tick();

        // rename r3 to A0 in the same cycle C1 retires: rename wins
        quiet(); issue(2'd1, 4'd3, 4'd0, 4'd0); bus.acceptor_tag_mul = 8'hA0; lane(0, 8'hC1, 32'd77); #1;
        chk("mul_strobe", bus.src_valid_mul, 1'b1);
        tick();

        quiet(); bus.instr_rs1 = 4'd3; #1;
        chk("rename_wins_tag", bus.src_out_1, 32'h0000_00A0);
        chk("rename_wins_type", bus.src_out1_type, 1'b1);
        chk("rename_wins_pending", bus.pending_count, 5'd1);

        // rd=0 dispatches but never renames
        quiet(); issue(2'd0, 4'd0, 4'd0, 4'd0); bus.acceptor_tag_add = 8'hC3; #1;
        chk("rd0_strobe", bus.src_valid_add, 1'b1);
        tick();
        quiet(); #1;
        chk("r0_value", bus.src_out_1, 32'd0);
        chk("r0_type", bus.src_out1_type, 1'b0);
        chk("rd0_pending", bus.pending_count, 5'd1);

        // mul station not ready: stall
        quiet(); issue(2'd1, 4'd5, 4'd0, 4'd0); bus.acceptor_tag_mul = 8'h42; bus.acceptor_tag_add = 8'hC7; #1;
        chk("stall_ready", bus.instr_ready, 1'b0);
        chk("stall_add", bus.src_valid_add, 1'b0);
        chk("stall_mul", bus.src_valid_mul, 1'b0);
        chk("stall_mem", bus.src_valid_mem, 1'b0);
        tick();
        quiet(); bus.instr_rs1 = 4'd5; #1;
        chk("stall_r5_type", bus.src_out1_type, 1'b0);
        chk("stall_pending", bus.pending_count, 5'd1);

        // illegal unit never accepted
        issue(2'd3, 4'd5, 4'd0, 4'd0); bus.acceptor_tag_add = 8'hC7; bus.acceptor_tag_mul = 8'hC8; bus.acceptor_tag_mem = 8'hC9; #1;
        chk("illegal_ready", bus.instr_ready, 1'b0);
        chk("illegal_strobe", bus.src_valid_add, 1'b0);

        // en=0 blocks the strobe and the rename
        quiet(); issue(2'd0, 4'd6, 4'd0, 4'd0); bus.acceptor_tag_add = 8'hC8; bus.en = 1'b0; #1;
        chk("en0_strobe", bus.src_valid_add, 1'b0);
        tick();
        quiet(); bus.instr_rs1 = 4'd6; #1;
        chk("en0_r6_type", bus.src_out1_type, 1'b0);
        chk("en0_pending", bus.pending_count, 5'd1);

        // r4 <- tag 91
        issue(2'd0, 4'd4, 4'd0, 4'd0); bus.acceptor_tag_add = 8'h91; #1;
        tick();
        quiet(); bus.instr_rs1 = 4'd4; #1;
        chk("r4_tag", bus.src_out_1, 32'h0000_0091);
        chk("pending_two", bus.pending_count, 5'd2);

        // rs1=r4 dispatches while lanes 0 and 1 both carry 91; lane 0 wins
        issue(2'd0, 4'd7, 4'd4, 4'd0); bus.acceptor_tag_add = 8'hC4;
        lane(0, 8'h91, 32'h0000_DEAD); lane(1, 8'h91, 32'h0000_BEEF); #1;
`ifdef CDB_BYPASS_EN
        chk("bypass_src1", bus.src_out_1, 32'h0000_DEAD);
        chk("bypass_type", bus.src_out1_type, 1'b0);
`else
        chk("nobypass_src1", bus.src_out_1, 32'h0000_0091);
        chk("nobypass_type", bus.src_out1_type, 1'b1);
`endif
        tick();
        quiet(); bus.instr_rs1 = 4'd4; bus.instr_rs2 = 4'd7; #1;
        chk("lane0_wins", bus.src_out_1, 32'h0000_DEAD);
        chk("r7_tag", bus.src_out_2, 32'h0000_00C4);
        chk("r7_type", bus.src_out2_type, 1'b1);
        chk("pending_after_bypass", bus.pending_count, 5'd2);

        // asynchronous reset mid-cycle with r3 busy
        bus.instr_rs1 = 4'd3; #1;
        reset = 1'b1; #1;
        chk("async_r3", bus.src_out_1, 32'd0);
        chk("async_r3_type", bus.src_out1_type, 1'b0);
        chk("async_pending", bus.pending_count, 5'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
